// File: rtl/mips_decode_exec_if.sv
// mips_decode_exec_if
//   Bundles the fetch/preload inputs, register-file operands and all
//   decode/ALU outputs of mips_decode_exec.
//   slave  modport : used by mips_decode_exec (drives decode/ALU results).
//   master modport : used by the surrounding datapath or a testbench.
//   Optional macro MIPS_ALU_OVF_EN adds the 1-bit ovf signal.
interface mips_decode_exec_if;
  logic [31:0] pc;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic [31:0] in_s1;
  logic [31:0] data_s2val;
  logic [31:0] instruction;
  logic [4:0]  address_s1;
  logic [4:0]  address_s2;
  logic [4:0]  address_d;
  logic [31:0] immediate;
  logic [5:0]  alu_opcode;
  logic        ALUSrc;
  logic        Jump;
  logic        Branch;
  logic        MemEnable;
  logic        MemWrite;
  logic        RegWrite;
  logic        MemtoReg;
  logic [31:0] res;
  logic        zero;
`ifdef MIPS_ALU_OVF_EN
  logic        ovf;
`endif

  modport slave (
    input  pc, load_en, load_addr, load_data, in_s1, data_s2val,
    output instruction, address_s1, address_s2, address_d, immediate,
    output alu_opcode, ALUSrc, Jump, Branch, MemEnable, MemWrite,
    output RegWrite, MemtoReg, res, zero
`ifdef MIPS_ALU_OVF_EN
    , output ovf
`endif
  );

  modport master (
    output pc, load_en, load_addr, load_data, in_s1, data_s2val,
    input  instruction, address_s1, address_s2, address_d, immediate,
    input  alu_opcode, ALUSrc, Jump, Branch, MemEnable, MemWrite,
    input  RegWrite, MemtoReg, res, zero
`ifdef MIPS_ALU_OVF_EN
    , input ovf
`endif
  );
endinterface

// File: rtl/mips_decode_exec.sv
// mips_decode_exec
//   Single-issue MIPS front/execute slice: instruction cache with a
//   registered fetch, a combinational decoder and a combinational ALU.
//   Ports:
//     clock   : rising-edge clock
//     reset_n : asynchronous active-low reset (clears the fetched word only)
//     bus     : mips_decode_exec_if.slave -- pc/preload inputs, register
//               operands in_s1/data_s2val, decode controls, res and zero.
//   Parameters: DEPTH (cache words), BASE_ADDR (byte address of word 0).
//   Optional macro MIPS_ALU_OVF_EN: signed overflow detection for
//   ADD/SUB/ADDI; ovf suppresses RegWrite.
module mips_decode_exec #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h8002_0000
) (
  input  logic clock,
  input  logic reset_n,
  mips_decode_exec_if.slave bus
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Word-aligned and inside the cache window.
  function automatic logic addr_in_range(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return (off[1:0] == 2'b00) && ({2'b00, off[31:2]} < 32'(DEPTH));
  endfunction

  function automatic logic [IW-1:0] addr_index(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return off[IW+1:2];
  endfunction

  logic [31:0] mem_q [DEPTH];
  logic [31:0] instr_d, instr_q;

  // Preload port; contents survive reset.
  always_ff @(posedge clock) begin
    if (bus.load_en && addr_in_range(bus.load_addr)) begin
      mem_q[addr_index(bus.load_addr)] <= bus.load_data;
    end
  end

  // Fetch lookup; out-of-range pc yields a NOP.
  always_comb begin
    instr_d = 32'h0000_0000;
    if (addr_in_range(bus.pc)) begin
      instr_d = mem_q[addr_index(bus.pc)];
    end else begin
      instr_d = 32'h0000_0000;
    end
  end

  // Fetched-word register; reset clears it without waiting for a clock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      instr_q <= 32'h0000_0000;
    end else begin
      instr_q <= instr_d;
    end
  end

  logic [5:0]  op_s, funct_s;
  logic [4:0]  rs_s, rt_s, rd_s, shamt_s;
  logic [15:0] imm16_s;
  logic [25:0] target_s;

  assign op_s     = instr_q[31:26];
  assign rs_s     = instr_q[25:21];
  assign rt_s     = instr_q[20:16];
  assign rd_s     = instr_q[15:11];
  assign shamt_s  = instr_q[10:6];
  assign funct_s  = instr_q[5:0];
  assign imm16_s  = instr_q[15:0];
  assign target_s = instr_q[25:0];

  logic [4:0]  s1_s, s2_s, d_s;
  logic [31:0] imm_s;
  logic [5:0]  alu_s;
  logic        alusrc_s, jump_s, beq_s, bne_s, memen_s, memwr_s, regwr_s, memtoreg_s;
`ifdef MIPS_ALU_OVF_EN
  logic        ovf_chk_s;
`endif

  // Instruction decode; anything unlisted leaves every control low.
  always_comb begin
    s1_s       = 5'd0;
    s2_s       = 5'd0;
    d_s        = 5'd0;
    imm_s      = 32'h0000_0000;
    alu_s      = 6'h3F;
    alusrc_s   = 1'b0;
    jump_s     = 1'b0;
    beq_s      = 1'b0;
    bne_s      = 1'b0;
    memen_s    = 1'b0;
    memwr_s    = 1'b0;
    regwr_s    = 1'b0;
    memtoreg_s = 1'b0;
`ifdef MIPS_ALU_OVF_EN
    ovf_chk_s  = 1'b0;
`endif
    case (op_s)
      6'h00: begin
        case (funct_s)
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: begin
            s1_s    = rs_s;
            s2_s    = rt_s;
            d_s     = rd_s;
            regwr_s = 1'b1;
            alu_s   = funct_s;
`ifdef MIPS_ALU_OVF_EN
            ovf_chk_s = (funct_s == 6'h20) || (funct_s == 6'h22);
`endif
          end
          // Shifts take the value from rt and the amount from shamt.
          6'h00, 6'h02, 6'h03: begin
            s1_s     = rt_s;
            d_s      = rd_s;
            imm_s    = {27'd0, shamt_s};
            alusrc_s = 1'b1;
            regwr_s  = 1'b1;
            alu_s    = funct_s;
          end
          default: begin
            alu_s = 6'h3F;
          end
        endcase
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        s1_s     = rs_s;
        d_s      = rt_s;
        alusrc_s = 1'b1;
        regwr_s  = 1'b1;
        case (op_s)
          6'h08, 6'h09: begin
            alu_s = 6'h21;
            imm_s = {{16{imm16_s[15]}}, imm16_s};
`ifdef MIPS_ALU_OVF_EN
            ovf_chk_s = (op_s == 6'h08);
`endif
          end
          6'h0A: begin
            alu_s = 6'h2A;
            imm_s = {{16{imm16_s[15]}}, imm16_s};
          end
          6'h0B: begin
            alu_s = 6'h2B;
            imm_s = {{16{imm16_s[15]}}, imm16_s};
          end
          6'h0C: begin
            alu_s = 6'h24;
            imm_s = {16'd0, imm16_s};
          end
          6'h0D: begin
            alu_s = 6'h25;
            imm_s = {16'd0, imm16_s};
          end
          6'h0E: begin
            alu_s = 6'h26;
            imm_s = {16'd0, imm16_s};
          end
          default: begin
            alu_s = 6'h0F;
            imm_s = {16'd0, imm16_s};
          end
        endcase
      end
      6'h23: begin
        s1_s       = rs_s;
        d_s        = rt_s;
        imm_s      = {{16{imm16_s[15]}}, imm16_s};
        alu_s      = 6'h21;
        alusrc_s   = 1'b1;
        memen_s    = 1'b1;
        memtoreg_s = 1'b1;
        regwr_s    = 1'b1;
      end
      6'h2B: begin
        s1_s     = rs_s;
        s2_s     = rt_s;
        imm_s    = {{16{imm16_s[15]}}, imm16_s};
        alu_s    = 6'h21;
        alusrc_s = 1'b1;
        memen_s  = 1'b1;
        memwr_s  = 1'b1;
      end
      6'h04, 6'h05: begin
        s1_s  = rs_s;
        s2_s  = rt_s;
        imm_s = {{14{imm16_s[15]}}, imm16_s, 2'b00};
        alu_s = 6'h23;
        beq_s = (op_s == 6'h04);
        bne_s = (op_s == 6'h05);
      end
      // JAL is treated as a plain jump (no link register write).
      6'h02, 6'h03: begin
        imm_s  = {6'd0, target_s};
        jump_s = 1'b1;
      end
      default: begin
        alu_s = 6'h3F;
      end
    endcase
  end

  logic [31:0] in_s2_s, res_s, sum_s, diff_s;

  assign in_s2_s = alusrc_s ? imm_s : bus.data_s2val;
  assign sum_s   = bus.in_s1 + in_s2_s;
  assign diff_s  = bus.in_s1 - in_s2_s;

  // ALU datapath; unsupported opcodes give 0.
  always_comb begin
    res_s = 32'h0000_0000;
    case (alu_s)
      6'h00:        res_s = bus.in_s1 << in_s2_s[4:0];
      6'h02:        res_s = bus.in_s1 >> in_s2_s[4:0];
      6'h03:        res_s = 32'($signed(bus.in_s1) >>> in_s2_s[4:0]);
      6'h0F:        res_s = {in_s2_s[15:0], 16'h0000};
      6'h20, 6'h21: res_s = sum_s;
      6'h22, 6'h23: res_s = diff_s;
      6'h24:        res_s = bus.in_s1 & in_s2_s;
      6'h25:        res_s = bus.in_s1 | in_s2_s;
      6'h26:        res_s = bus.in_s1 ^ in_s2_s;
      6'h27:        res_s = ~(bus.in_s1 | in_s2_s);
      6'h2A:        res_s = {31'd0, $signed(bus.in_s1) < $signed(in_s2_s)};
      6'h2B:        res_s = {31'd0, bus.in_s1 < in_s2_s};
      default:      res_s = 32'h0000_0000;
    endcase
  end

  logic zero_s;
  assign zero_s = (res_s == 32'h0000_0000);

`ifdef MIPS_ALU_OVF_EN
  logic ovf_s;
  // Signed overflow: same-sign add or opposite-sign subtract flips the sign.
  always_comb begin
    ovf_s = 1'b0;
    if (ovf_chk_s && (alu_s == 6'h22)) begin
      ovf_s = (bus.in_s1[31] != in_s2_s[31]) && (diff_s[31] != bus.in_s1[31]);
    end else if (ovf_chk_s) begin
      ovf_s = (bus.in_s1[31] == in_s2_s[31]) && (sum_s[31] != bus.in_s1[31]);
    end else begin
      ovf_s = 1'b0;
    end
  end
  assign bus.ovf      = ovf_s;
  assign bus.RegWrite = regwr_s & ~ovf_s;
`else
  assign bus.RegWrite = regwr_s;
`endif

  assign bus.instruction = instr_q;
  assign bus.address_s1  = s1_s;
  assign bus.address_s2  = s2_s;
  assign bus.address_d   = d_s;
  assign bus.immediate   = imm_s;
  assign bus.alu_opcode  = alu_s;
  assign bus.ALUSrc      = alusrc_s;
  assign bus.Jump        = jump_s;
  assign bus.Branch      = (beq_s & zero_s) | (bne_s & ~zero_s);
  assign bus.MemEnable   = memen_s;
  assign bus.MemWrite    = memwr_s;
  assign bus.MemtoReg    = memtoreg_s;
  assign bus.res         = res_s;
  assign bus.zero        = zero_s;

endmodule

// File: tb/tb_mips_decode_exec.sv
// Scoreboard bench for mips_decode_exec: the stimulus thread queues the
// expected decode/ALU picture for each applied vector, and a monitor on the
// falling clock edge pops and compares whatever the DUT presents.
module tb_mips_decode_exec;

  localparam logic [31:0] BASE  = 32'h8002_0000;
  localparam int          DEPTH = 1024;

  typedef struct packed {
    logic [31:0] instr;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [4:0]  d;
    logic [31:0] imm;
    logic [5:0]  alu;
    logic [6:0]  ctrl;   // {ALUSrc,Jump,Branch,MemEnable,MemWrite,RegWrite,MemtoReg}
    logic [31:0] res;
    logic        zero;
  } obs_t;

  typedef struct packed {
    obs_t        exp;
    obs_t        mask;
    logic [95:0] tag;
  } entry_t;

  logic clock;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;
  entry_t sb_q[$];

  mips_decode_exec_if bus();

  mips_decode_exec #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] waddr(input int i);
    return BASE + 32'(4 * i);
  endfunction

  function automatic obs_t mk(input logic [31:0] instr, input logic [4:0] s1, s2, d,
                              input logic [31:0] imm, input logic [5:0] alu,
                              input logic [6:0] ctrl, input logic [31:0] res);
    obs_t o;
    o.instr = instr; o.s1 = s1; o.s2 = s2; o.d = d; o.imm = imm;
    o.alu = alu; o.ctrl = ctrl; o.res = res; o.zero = (res == 32'h0);
    return o;
  endfunction

  function automatic obs_t mkmask(input logic cs1, cs2, cd, cimm, calu, cres);
    obs_t m;
    m.instr = '1; m.ctrl = '1;
    m.s1 = {5{cs1}}; m.s2 = {5{cs2}}; m.d = {5{cd}};
    m.imm = {32{cimm}}; m.alu = {6{calu}};
    m.res = {32{cres}}; m.zero = cres;
    return m;
  endfunction

  // Monitor: compare the DUT picture against the oldest queued expectation.
  always @(negedge clock) begin
    if (sb_q.size() > 0) begin
      entry_t e;
      obs_t   act;
      e = sb_q.pop_front();
      act.instr = bus.instruction;
      act.s1    = bus.address_s1;
      act.s2    = bus.address_s2;
      act.d     = bus.address_d;
      act.imm   = bus.immediate;
      act.alu   = bus.alu_opcode;
      act.ctrl  = {bus.ALUSrc, bus.Jump, bus.Branch, bus.MemEnable,
                   bus.MemWrite, bus.RegWrite, bus.MemtoReg};
      act.res   = bus.res;
      act.zero  = bus.zero;
      checks++;
      if (((act ^ e.exp) & e.mask) != '0) begin
        errors++;
        $display("FAIL %s: got %h want %h (care %h)", e.tag, act, e.exp, e.mask);
      end
    end
  end

  task automatic apply(input logic [31:0] p, a, b, input obs_t exp, input obs_t mask,
                       input logic [95:0] tag);
    entry_t e;
    bus.pc = p; bus.in_s1 = a; bus.data_s2val = b;
    e.exp = exp; e.mask = mask; e.tag = tag;
    sb_q.push_back(e);
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] prog [12];
    obs_t m_r, m_i, m_sw, m_b, m_j, m_u;
    entry_t e;
    int wait_cnt;

    prog[0]  = 32'h2008_0005;  // addi t0, zero, 5
    prog[1]  = 32'h0109_5022;  // sub
    prog[2]  = 32'h0109_502A;  // slt
    prog[3]  = 32'h0109_502B;  // sltu
    prog[4]  = 32'h1109_FFFE;  // beq
    prog[5]  = 32'h8D2A_0004;  // lw
    prog[6]  = 32'hAD2A_0004;  // sw
    prog[7]  = 32'h3128_F0F0;  // andi r8, r9, 0xF0F0
    prog[8]  = 32'h0009_5103;  // sra r10, r9, 4
    prog[9]  = 32'h3C0A_1234;  // lui r10, 0x1234
    prog[10] = 32'h0800_0010;  // j 0x10
    prog[11] = 32'h0109_5020;  // add

    m_r  = mkmask(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    m_i  = mkmask(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    m_sw = mkmask(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    m_b  = mkmask(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    m_j  = mkmask(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    m_u  = mkmask(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    reset_n = 1'b0;
    bus.pc = 32'h0; bus.load_en = 1'b0; bus.load_addr = 32'h0; bus.load_data = 32'h0;
    bus.in_s1 = 32'h0; bus.data_s2val = 32'h0;
    #1;
    e.exp = mk(32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 6'h00, 7'b1000010, 32'h0);
    e.mask = m_i; e.tag = "reset";
    sb_q.push_back(e);
    @(negedge clock);
    #1;
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      bus.load_en = 1'b1; bus.load_addr = waddr(i); bus.load_data = prog[i];
      @(posedge clock);
      @(negedge clock);
      #1;
    end
    bus.load_en = 1'b0;

    apply(waddr(0), 32'h0, 32'h0,
          mk(prog[0], 5'd0, 5'd0, 5'd8, 32'h5, 6'h21, 7'b1000010, 32'h5), m_i, "addi");
    apply(waddr(1), 32'h3, 32'h7,
          mk(prog[1], 5'd8, 5'd9, 5'd10, 32'h0, 6'h22, 7'b0000010, 32'hFFFF_FFFC), m_r, "sub");
    apply(waddr(2), 32'h3, 32'h7,
          mk(prog[2], 5'd8, 5'd9, 5'd10, 32'h0, 6'h2A, 7'b0000010, 32'h1), m_r, "slt");
    apply(waddr(3), 32'hFFFF_FFFF, 32'h1,
          mk(prog[3], 5'd8, 5'd9, 5'd10, 32'h0, 6'h2B, 7'b0000010, 32'h0), m_r, "sltu");
    apply(waddr(4), 32'h9, 32'h9,
          mk(prog[4], 5'd8, 5'd9, 5'd0, 32'hFFFF_FFF8, 6'h23, 7'b0010000, 32'h0), m_b, "beq_taken");
    apply(waddr(4), 32'h9, 32'h8,
          mk(prog[4], 5'd8, 5'd9, 5'd0, 32'hFFFF_FFF8, 6'h23, 7'b0000000, 32'h1), m_b, "beq_not");
    apply(waddr(6), 32'h100, 32'h0,
          mk(prog[6], 5'd9, 5'd10, 5'd0, 32'h4, 6'h21, 7'b1001100, 32'h104), m_sw, "sw");
    apply(waddr(7), 32'hFFFF_0FFF, 32'h0,
          mk(prog[7], 5'd9, 5'd0, 5'd8, 32'h0000_F0F0, 6'h24, 7'b1000010, 32'h0000_00F0), m_i, "andi");
    apply(waddr(8), 32'h8000_0000, 32'h0,
          mk(prog[8], 5'd9, 5'd0, 5'd10, 32'h4, 6'h03, 7'b1000010, 32'hF800_0000), m_i, "sra");
    apply(waddr(9), 32'hDEAD_BEEF, 32'h0,
          mk(prog[9], 5'd0, 5'd0, 5'd10, 32'h1234, 6'h0F, 7'b1000010, 32'h1234_0000), m_i, "lui");
    apply(waddr(10), 32'h0, 32'h0,
          mk(prog[10], 5'd0, 5'd0, 5'd0, 32'h10, 6'h3F, 7'b0100000, 32'h0), m_j, "jump");
`ifdef MIPS_ALU_OVF_EN
    apply(waddr(11), 32'h7FFF_FFFF, 32'h1,
          mk(prog[11], 5'd8, 5'd9, 5'd10, 32'h0, 6'h20, 7'b0000000, 32'h8000_0000), m_r, "add_ovf");
`else
    apply(waddr(11), 32'h7FFF_FFFF, 32'h1,
          mk(prog[11], 5'd8, 5'd9, 5'd10, 32'h0, 6'h20, 7'b0000010, 32'h8000_0000), m_r, "add_wrap");
`endif
    apply(BASE + 32'(4 * DEPTH), 32'h55, 32'h0,
          mk(32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 6'h00, 7'b1000010, 32'h55), m_i, "pc_oor");
    apply(BASE + 32'h1, 32'h0, 32'h0,
          mk(32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 6'h00, 7'b1000010, 32'h0), m_i, "pc_misalign");
    apply(waddr(5), 32'h100, 32'h0,
          mk(prog[5], 5'd9, 5'd0, 5'd10, 32'h4, 6'h21, 7'b1001011, 32'h104), m_i, "lw");

    // Mid-run reset well away from any clock edge: instruction clears at once.
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    bus.in_s1 = 32'h100;
    e.exp = mk(32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 6'h00, 7'b1000010, 32'h100);
    e.mask = m_i; e.tag = "async_rst";
    sb_q.push_back(e);
    @(negedge clock);
    #1;
    reset_n = 1'b1;

    apply(waddr(1), 32'h3, 32'h7,
          mk(prog[1], 5'd8, 5'd9, 5'd10, 32'h0, 6'h22, 7'b0000010, 32'hFFFF_FFFC), m_r, "mem_kept");

    // Load and fetch of the same word on one edge: fetch sees the old word.
    bus.load_en = 1'b1; bus.load_addr = waddr(0); bus.load_data = 32'hFC00_0000;
    apply(waddr(0), 32'h0, 32'h0,
          mk(prog[0], 5'd0, 5'd0, 5'd8, 32'h5, 6'h21, 7'b1000010, 32'h5), m_i, "rd_old");
    bus.load_en = 1'b0;
    apply(waddr(0), 32'h1234, 32'h5678,
          mk(32'hFC00_0000, 5'd0, 5'd0, 5'd0, 32'h0, 6'h3F, 7'b0000000, 32'h0), m_u, "unknown_op");

    wait_cnt = 0;
    while (sb_q.size() > 0 && wait_cnt < 10) begin
      @(negedge clock);
      #1;
      wait_cnt++;
    end
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, want 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_decode_exec.md
Name: mips_decode_exec

Overview:
- Single-issue MIPS front/execute slice: instruction cache (fetch RAM), instruction decoder, and ALU in one clocked block.
- Takes the PC, fetches the instruction word, decodes register addresses, immediate and control signals, and computes the ALU result from register operands supplied by the external register file.
- Sits between the program counter and register file / data cache in the single-cycle datapath.

Parameters:
- DEPTH, 1024, instruction words held in the cache.
- BASE_ADDR, 32'h8002_0000, byte address of cache word 0.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- pc  in  32  fetch byte address.
- load_en  in  1  write enable for cache preload.
- load_addr  in  32  byte address for preload.
- load_data  in  32  instruction word to preload.
- in_s1  in  32  register-file value for address_s1.
- data_s2val  in  32  register-file value for address_s2.
- instruction  out  32  registered fetched word.
- address_s1  out  5  source register 1.
- address_s2  out  5  source register 2.
- address_d  out  5  destination register.
- immediate  out  32  decoded immediate.
- alu_opcode  out  6  ALU operation code.
- ALUSrc  out  1  1 = ALU operand 2 is immediate.
- Jump  out  1  take jump.
- Branch  out  1  take branch (condition already resolved).
- MemEnable  out  1  data-cache access.
- MemWrite  out  1  1 = store, 0 = load.
- RegWrite  out  1  register write enable.
- MemtoReg  out  1  1 = writeback from memory.
- res  out  32  ALU result.
- zero  out  1  res == 0.

Behaviour:
- Cache storage:
  - Word index = (addr - BASE_ADDR) >> 2; in range when index < DEPTH and addr[1:0] == 0.
  - load_en writes load_data on the rising edge if load_addr is in range; out-of-range loads are ignored.
  - Storage is not cleared by reset.
- Fetch:
  - instruction <= mem[index] on each rising edge: one-cycle latency.
  - An out-of-range pc yields 32'h0 (NOP).
  - Reset forces instruction to 0.
  - Simultaneous load and fetch of the same word returns the old data.
- Decode: combinational from instruction. Fields: op [31:26], rs, rt, rd, shamt, funct, imm16, target26.
- R-type (op 0):
  - address_s1 = rs, address_s2 = rt, address_d = rd, RegWrite = 1, alu_opcode = funct.
  - Supported funct: 20 ADD, 21 ADDU, 22 SUB, 23 SUBU, 24 AND, 25 OR, 26 XOR, 27 NOR, 2A SLT, 2B SLTU.
  - Shifts (funct 00 SLL, 02 SRL, 03 SRA): address_s1 = rt, immediate = zero-extended shamt, ALUSrc = 1.
- I-type: address_s1 = rs, address_d = rt, ALUSrc = 1, RegWrite = 1.
  - ADDI/ADDIU (08/09) -> 21, sign-extended immediate.
  - ANDI/ORI/XORI (0C/0D/0E) -> 24/25/26, zero-extended immediate.
  - SLTI/SLTIU (0A/0B) -> 2A/2B, sign-extended immediate.
  - LUI (0F) -> 0F (res = in_s2 << 16).
- LW (23): alu 21, sign-extended immediate, MemEnable = 1, MemtoReg = 1, MemWrite = 0.
- SW (2B): address_s2 = rt, alu 21, MemEnable = 1, MemWrite = 1, RegWrite = 0.
- BEQ (04) / BNE (05):
  - address_s2 = rt, ALUSrc = 0, alu 23, RegWrite = 0.
  - immediate = sign-extended imm16 << 2.
  - Branch = zero for BEQ, !zero for BNE.
- J (02) / JAL (03):
  - immediate = zero-extended target26, Jump = 1, RegWrite = 0.
  - JAL does not link.
- Unlisted op or funct: all control outputs 0, alu_opcode 0x3F, res 0.
- ALU operand 2 (in_s2) = ALUSrc ? immediate : data_s2val.
- ALU arithmetic:
  - ADD/ADDU/SUB/SUBU wrap modulo 2^32.
  - SLT is signed; SLTU is unsigned; both return 0 or 1.
  - Shifts operate on in_s1 by in_s2[4:0]; SRA is arithmetic.
- zero is combinational from res.
- During reset all outputs derive from instruction = 0 (SLL r0, r0, 0): RegWrite = 1, res = in_s1 shifted by 0.

Optional Feature:
- MIPS_ALU_OVF_EN defined:
  - Adds output port ovf (1 bit): high when ADD, SUB or ADDI overflows in signed arithmetic.
  - While ovf is high, RegWrite is forced to 0.
- MIPS_ALU_OVF_EN undefined: no ovf port; ADD/SUB/ADDI behave as ADDU/SUBU/ADDIU.

Test Plan:
- Preload word 0 = 32'h2008_0005 (addi t0, zero, 5); pc = 0x80020000, in_s1 = 0 -> next cycle: address_d = 8, immediate = 5, ALUSrc = 1, RegWrite = 1, res = 5.
- R-type sub (32'h0109_5022); in_s1 = 3, data_s2val = 7 -> res = 0xFFFF_FFFC, zero = 0; SLT of the same operands -> res = 1; SLTU with in_s1 = 0xFFFF_FFFF, data_s2val = 1 -> res = 0.
- BEQ (32'h1109_FFFE); in_s1 = data_s2val = 9 -> Branch = 1, immediate = 0xFFFF_FFF8; then data_s2val = 8 -> Branch = 0.
- LW (32'h8D2A_0004); in_s1 = 0x100 -> res = 0x104, MemEnable = 1, MemtoReg = 1. SW (32'hAD2A_0004) -> MemWrite = 1, RegWrite = 0.
- Fetch at pc = BASE_ADDR + 4*DEPTH -> instruction = 0. Assert reset_n low mid-run -> instruction = 0 immediately, with no wait for a clock edge.
- With MIPS_ALU_OVF_EN: ADD, in_s1 = 0x7FFF_FFFF, data_s2val = 1 -> ovf = 1, RegWrite = 0. Unknown opcode 0x3F -> all controls 0.
